alu_multicycle: RTL and testbench
=================================

ALU_MULTICYCLE -- requirements
Module: alu_multicycle

Interface
REQ-001 SHALL have parameter WIDTH, default 32, the operand and result width in bits (legal range 8..64).
REQ-002 SHALL have port clk  input  1  the single clock; all state updates on its rising edge.
REQ-003 SHALL have port rst_n  input  1  reset; synchronous and active-low.
REQ-004 SHALL have port in_valid  input  1  operation request.
REQ-005 SHALL have port in_ready  output  1  block can accept a request.
REQ-006 SHALL have port data1  input  WIDTH  first operand.
REQ-007 SHALL have port data2  input  WIDTH  second operand.
REQ-008 SHALL have port aluControl  input  4  opcode.
REQ-009 SHALL have port out_valid  output  1  result fields valid.
REQ-010 SHALL have port out_ready  input  1  consumer accepts result.
REQ-011 SHALL have port out  output  WIDTH  result.
REQ-012 SHALL have port zero  output  1  out equals 0.
REQ-013 SHALL have port overflow  output  1  signed ADD/SUB overflow, or DIVU divide-by-zero.
REQ-014 SHALL have port illegal  output  1  opcode not in REQ-017.

Function
REQ-015 SHALL implement states IDLE, BUSY, DONE; in_ready = 1 only in IDLE.
REQ-016 SHALL accept a request on a clock edge where in_valid and in_ready are both 1; it SHALL capture data1, data2 and aluControl on that edge and ignore all three afterwards.
REQ-017 SHALL decode the opcodes: 0000 AND; 0001 OR; 0010 ADD; 0110 SUB; 0111 SLT (signed, out = 1 or 0); 1100 NOR; 1000 MUL (unsigned, low WIDTH bits of product); 1001 DIVU (unsigned quotient).
REQ-018 SHALL, for single-cycle opcodes, go IDLE->DONE on acceptance, with out_valid = 1 on the first cycle after acceptance.
REQ-019 SHALL, for MUL and DIVU, go IDLE->BUSY on acceptance and iterate one bit per cycle for WIDTH cycles, by shift-add for MUL and restoring division for DIVU.
REQ-020 SHALL go BUSY->DONE after those WIDTH cycles; out_valid SHALL first be 1 exactly WIDTH+1 cycles after acceptance.
REQ-021 SHALL hold out, zero, overflow and illegal stable in DONE while out_ready = 0.
REQ-022 SHALL go DONE->IDLE on an edge where out_valid = 1 and out_ready = 1; out_valid SHALL then be 0 on the next cycle.
REQ-023 SHALL NOT accept a new request on the same edge as a DONE handshake (minimum issue interval of 2 cycles for single-cycle ops).
REQ-024 SHALL set overflow for ADD when both operand signs are equal and the result sign differs.
REQ-025 SHALL set overflow for SUB when the operand signs differ and the result sign differs from data1.
REQ-026 SHALL set overflow = 0 for all other opcodes, except REQ-027.
REQ-027 SHALL, for DIVU with data2 = 0, still take WIDTH+1 cycles and return out = all ones with overflow = 1.
REQ-028 SHALL, for an illegal opcode, complete as a single-cycle op with out = 0, zero = 1, illegal = 1, overflow = 0.
REQ-029 SHALL derive zero from the registered out, so it is valid whenever out_valid = 1.
REQ-030 SHALL use no combinational path from in_valid or out_ready to in_ready or out_valid.

Reset
REQ-031 SHALL, on any edge with rst_n = 0 and in any state, go to IDLE with out_valid = 0, out = 0, zero = 0, overflow = 0, illegal = 0, iteration counter = 0.
REQ-032 SHALL, when rst_n = 0 during BUSY or DONE, abort the operation and discard its result; no out_valid pulse SHALL follow.
REQ-033 SHALL give rst_n priority over every simultaneous in_valid or out_ready event; in_ready SHALL be 1 on the first cycle after rst_n returns to 1.

Verification (WIDTH = 32)
REQ-034 SHALL cover: ADD 0x7FFFFFFF + 0x00000001 -> out_valid 1 cycle later, out = 0x80000000, overflow = 1, zero = 0.
REQ-035 SHALL cover: MUL 0x00010000 * 0x00010000 -> out_valid exactly 33 cycles after acceptance, out = 0, zero = 1; MUL 12345 * 678 -> out = 8369910.
REQ-036 SHALL cover: DIVU 100 / 7 -> out = 14 after 33 cycles; DIVU 5 / 0 -> out = 0xFFFFFFFF, overflow = 1.
REQ-037 SHALL cover: SUB 0x80000000 - 1 -> out = 0x7FFFFFFF, overflow = 1, with out_ready held 0 for 3 cycles -> out unchanged, in_ready = 0 throughout.
REQ-038 SHALL cover: rst_n = 0 on cycle 10 of a MUL -> no out_valid, in_ready = 1 on the cycle after rst_n rises.
REQ-039 SHALL cover: aluControl = 1111 -> out = 0, illegal = 1, zero = 1; SLT 0xFFFFFFFF vs 0x00000001 -> out = 1.

Source files
------------

// File: rtl/alu_multicycle.sv
// Multi-cycle ALU with a valid/ready handshake. Logic ops, ADD, SUB and SLT finish
// in one cycle; MUL (shift-add) and DIVU (restoring) iterate one bit per cycle.
module alu_multicycle #(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] data1,
    input  logic [WIDTH-1:0] data2,
    input  logic [3:0]       aluControl,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out,
    output logic             zero,
    output logic             overflow,
    output logic             illegal
);

    localparam int CW = $clog2(WIDTH);
    localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

    localparam logic [3:0] OP_AND  = 4'b0000;
    localparam logic [3:0] OP_OR   = 4'b0001;
    localparam logic [3:0] OP_ADD  = 4'b0010;
    localparam logic [3:0] OP_SUB  = 4'b0110;
    localparam logic [3:0] OP_SLT  = 4'b0111;
    localparam logic [3:0] OP_NOR  = 4'b1100;
    localparam logic [3:0] OP_MUL  = 4'b1000;
    localparam logic [3:0] OP_DIVU = 4'b1001;

    typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;

    state_t           state;
    logic [CW-1:0]    count;
    logic             is_div;
    logic             div_zero;
    logic [WIDTH-1:0] op_a;
    logic [WIDTH-1:0] op_b;
    logic [WIDTH-1:0] acc;

    logic [WIDTH-1:0] sum;
    logic [WIDTH-1:0] dif;
    logic [WIDTH-1:0] sc_out;
    logic             sc_ovf;
    logic             sc_ill;
    logic             is_multi;

    logic [WIDTH-1:0] mul_acc_nxt;
    logic [WIDTH:0]   div_shift;
    logic [WIDTH:0]   div_diff;
    logic [WIDTH-1:0] div_rem_nxt;
    logic [WIDTH-1:0] div_q_nxt;
    logic [WIDTH-1:0] result_nxt;

    assign in_ready = (state == IDLE);
    assign is_multi = (aluControl == OP_MUL) || (aluControl == OP_DIVU);

    always_comb begin
        sum    = data1 + data2;
        dif    = data1 - data2;
        sc_out = '0;
        sc_ovf = 1'b0;
        sc_ill = 1'b0;
        case (aluControl)
            OP_AND: sc_out = data1 & data2;
            OP_OR:  sc_out = data1 | data2;
            OP_NOR: sc_out = ~(data1 | data2);
            OP_ADD: begin
                sc_out = sum;
                sc_ovf = (data1[WIDTH-1] == data2[WIDTH-1]) && (sum[WIDTH-1] != data1[WIDTH-1]);
            end
            OP_SUB: begin
                sc_out = dif;
                sc_ovf = (data1[WIDTH-1] != data2[WIDTH-1]) && (dif[WIDTH-1] != data1[WIDTH-1]);
            end
            OP_SLT:  sc_out = {{(WIDTH-1){1'b0}}, ($signed(data1) < $signed(data2))};
            OP_MUL, OP_DIVU: sc_out = '0;
            default: sc_ill = 1'b1;
        endcase
    end

    // One iteration step: op_a is multiplicand/divisor, op_b multiplier/quotient.
    always_comb begin
        mul_acc_nxt = op_b[0] ? acc + op_a : acc;
        div_shift   = {acc, op_b[WIDTH-1]};
        div_diff    = div_shift - {1'b0, op_a};
        if (!div_diff[WIDTH]) begin
            div_rem_nxt = div_diff[WIDTH-1:0];
            div_q_nxt   = {op_b[WIDTH-2:0], 1'b1};
        end else begin
            div_rem_nxt = div_shift[WIDTH-1:0];
            div_q_nxt   = {op_b[WIDTH-2:0], 1'b0};
        end
        result_nxt = is_div ? div_q_nxt : mul_acc_nxt;
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state     <= IDLE;
            count     <= '0;
            is_div    <= 1'b0;
            div_zero  <= 1'b0;
            out_valid <= 1'b0;
            out       <= '0;
            zero      <= 1'b0;
            overflow  <= 1'b0;
            illegal   <= 1'b0;
        end else begin
            case (state)
                IDLE: if (in_valid) begin
                    count    <= '0;
                    is_div   <= (aluControl == OP_DIVU);
                    div_zero <= (data2 == '0);
                    if (is_multi) begin
                        state <= BUSY;
                    end else begin
                        state     <= DONE;
                        out_valid <= 1'b1;
                        out       <= sc_out;
                        zero      <= (sc_out == '0);
                        overflow  <= sc_ovf;
                        illegal   <= sc_ill;
                    end
                end
                BUSY: begin
                    count <= count + CW'(1);
                    if (count == LAST) begin
                        state     <= DONE;
                        out_valid <= 1'b1;
                        out       <= result_nxt;
                        zero      <= (result_nxt == '0);
                        overflow  <= is_div && div_zero;
                        illegal   <= 1'b0;
                    end
                end
                DONE: if (out_ready) begin
                    state     <= IDLE;
                    out_valid <= 1'b0;
                end
                default: state <= IDLE;
            endcase
        end
    end

    // NOTE: pure datapath registers carry no reset; they are always loaded on acceptance before use.
    always_ff @(posedge clk) begin
        if (state == IDLE && in_valid) begin
            op_a <= (aluControl == OP_DIVU) ? data2 : data1;
            op_b <= (aluControl == OP_DIVU) ? data1 : data2;
            acc  <= '0;
        end else if (state == BUSY) begin
            acc  <= is_div ? div_rem_nxt : mul_acc_nxt;
            op_a <= is_div ? op_a : op_a << 1;
            op_b <= is_div ? div_q_nxt : op_b >> 1;
        end
    end

endmodule

// File: tb/tb_alu_multicycle.sv
// Scoreboard bench for alu_multicycle (WIDTH=32): the driver queues hand-computed
// results, a monitor pops and checks them whenever out_valid rises.
module tb_alu_multicycle;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        in_valid = 1'b0;
    logic        in_ready;
    logic [31:0] data1 = '0;
    logic [31:0] data2 = '0;
    logic [3:0]  aluControl = '0;
    logic        out_valid;
    logic        out_ready = 1'b1;
    logic [31:0] out;
    logic        zero;
    logic        overflow;
    logic        illegal;

    int checks = 0;
    int errors = 0;
    int cyc = 0;

    typedef struct {
        logic [31:0] res;
        logic        ovf;
        logic        ill;
        int          lat;
        int          acc_cyc;
        string       name;
    } exp_t;

    exp_t exp_q[$];

    alu_multicycle #(.WIDTH(32)) dut (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
        .data1(data1), .data2(data2), .aluControl(aluControl),
        .out_valid(out_valid), .out_ready(out_ready), .out(out),
        .zero(zero), .overflow(overflow), .illegal(illegal)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s: got %0h, expected %0h", name, act, req);
        end
    endtask

    // Called at a negedge; returns at the negedge following the acceptance edge.
    task automatic issue(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b,
                         input logic [31:0] res, input logic ovf, input logic ill,
                         input int lat, input string name, input bit push = 1'b1);
        int guard = 0;
        exp_t e;
        in_valid   = 1'b1;
        data1      = a;
        data2      = b;
        aluControl = op;
        while (!in_ready && guard < 200) begin
            @(negedge clk);
            guard++;
        end
        if (!in_ready) check({name, "_accept_timeout"}, 64'd1, 64'd0);
        if (push) begin
            e.res = res; e.ovf = ovf; e.ill = ill; e.lat = lat;
            e.acc_cyc = cyc + 1; e.name = name;
            exp_q.push_back(e);
        end
        @(negedge clk);
        in_valid   = 1'b0;
        data1      = $urandom;
        data2      = $urandom;
        aluControl = 4'($urandom);
    endtask

    task automatic drain();
        int guard = 0;
        while ((exp_q.size() != 0 || out_valid) && guard < 200) begin
            @(negedge clk);
            guard++;
        end
        check("drain_queue_empty", 64'(exp_q.size()), 64'd0);
    endtask

    initial begin : monitor
        bit   prev_valid = 1'b0;
        exp_t cur;
        forever begin
            @(negedge clk);
            if (out_valid && !prev_valid) begin
                if (exp_q.size() == 0) begin
                    check("unexpected_out_valid", 64'd1, 64'd0);
                end else begin
                    cur = exp_q.pop_front();
                    check({cur.name, "_out"}, 64'(out), 64'(cur.res));
                    check({cur.name, "_zero"}, 64'(zero), 64'(cur.res == 32'd0));
                    check({cur.name, "_overflow"}, 64'(overflow), 64'(cur.ovf));
                    check({cur.name, "_illegal"}, 64'(illegal), 64'(cur.ill));
                    check({cur.name, "_latency"}, 64'(cyc - cur.acc_cyc + 1), 64'(cur.lat));
                end
            end else if (out_valid) begin
                check({cur.name, "_hold_out"}, 64'(out), 64'(cur.res));
                check({cur.name, "_hold_ovf"}, 64'(overflow), 64'(cur.ovf));
                check({cur.name, "_hold_in_ready"}, 64'(in_ready), 64'd0);
            end
            prev_valid = out_valid;
        end
    end

    initial begin : watchdog
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog expired");
    end

    initial begin : stimulus
        int pulses;
        repeat (3) @(negedge clk);
        check("reset_out_valid", 64'(out_valid), 64'd0);
        check("reset_out", 64'(out), 64'd0);
        check("reset_zero", 64'(zero), 64'd0);
        check("reset_overflow", 64'(overflow), 64'd0);
        check("reset_illegal", 64'(illegal), 64'd0);
        check("reset_in_ready", 64'(in_ready), 64'd1);
        rst_n = 1'b1;
        @(negedge clk);

        issue(4'b0010, 32'h7FFF_FFFF, 32'h0000_0001, 32'h8000_0000, 1'b1, 1'b0, 1, "add_ovf");
        issue(4'b0010, 32'h0000_0005, 32'hFFFF_FFFB, 32'h0000_0000, 1'b0, 1'b0, 1, "add_zero");
        issue(4'b0110, 32'h0000_0003, 32'h0000_0005, 32'hFFFF_FFFE, 1'b0, 1'b0, 1, "sub_neg");
        issue(4'b0000, 32'hF0F0_F0F0, 32'h0FF0_0FF0, 32'h00F0_00F0, 1'b0, 1'b0, 1, "and");
        issue(4'b0001, 32'h0000_FF00, 32'h00FF_0000, 32'h00FF_FF00, 1'b0, 1'b0, 1, "or");
        issue(4'b1100, 32'h0000_0000, 32'h0000_0000, 32'hFFFF_FFFF, 1'b0, 1'b0, 1, "nor_ones");
        issue(4'b1100, 32'hFFFF_FFFF, 32'h0000_0000, 32'h0000_0000, 1'b0, 1'b0, 1, "nor_zero");
        issue(4'b0111, 32'hFFFF_FFFF, 32'h0000_0001, 32'h0000_0001, 1'b0, 1'b0, 1, "slt_true");
        issue(4'b0111, 32'h0000_0001, 32'hFFFF_FFFF, 32'h0000_0000, 1'b0, 1'b0, 1, "slt_false");
        issue(4'b1111, 32'h1234_5678, 32'h9ABC_DEF0, 32'h0000_0000, 1'b0, 1'b1, 1, "illegal");
        issue(4'b1000, 32'h0001_0000, 32'h0001_0000, 32'h0000_0000, 1'b0, 1'b0, 33, "mul_wrap");
        issue(4'b1000, 32'd12345, 32'd678, 32'd8369910, 1'b0, 1'b0, 33, "mul_small");
        issue(4'b1000, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'h0000_0001, 1'b0, 1'b0, 33, "mul_max");
        issue(4'b1001, 32'd100, 32'd7, 32'd14, 1'b0, 1'b0, 33, "divu_100_7");
        issue(4'b1001, 32'd5, 32'd0, 32'hFFFF_FFFF, 1'b1, 1'b0, 33, "divu_by_zero");
        issue(4'b1001, 32'hFFFF_FFFF, 32'd1, 32'hFFFF_FFFF, 1'b0, 1'b0, 33, "divu_by_one");
        issue(4'b1001, 32'd7, 32'd100, 32'd0, 1'b0, 1'b0, 33, "divu_small");
        drain();

        out_ready = 1'b0;
        issue(4'b0110, 32'h8000_0000, 32'h0000_0001, 32'h7FFF_FFFF, 1'b1, 1'b0, 1, "sub_stall");
        repeat (4) @(negedge clk);
        out_ready = 1'b1;
        drain();

        issue(4'b1000, 32'd3, 32'd4, 32'd12, 1'b0, 1'b0, 33, "mul_aborted", 1'b0);
        repeat (8) @(negedge clk);
        rst_n = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        check("post_reset_in_ready", 64'(in_ready), 64'd1);
        check("post_reset_out_valid", 64'(out_valid), 64'd0);
        pulses = 0;
        repeat (40) begin
            @(negedge clk);
            if (out_valid) pulses++;
        end
        check("aborted_no_out_valid", 64'(pulses), 64'd0);

        issue(4'b0010, 32'd2, 32'd3, 32'd5, 1'b0, 1'b0, 1, "add_after_reset");
        drain();

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
